// File: rtl/keccak_hash_scheduler.sv
// Control sequencer for the shared Keccak-f[1600] datapath: arbitrates two requesters
// and steps each job through clear, per-block absorb + 24-round permute, then squeeze.
module keccak_hash_scheduler #(
    parameter int NUM_ROUNDS = 24,
    parameter int RATE_LANES = 17,
    parameter int OUT_LANES  = 4,
    parameter int BLK_W      = 8
) (
    input  logic             ex_clk,
    input  logic             ovr_rst_n,
    input  logic [1:0]       req,
    input  logic [BLK_W-1:0] req_nblk0,
    input  logic [BLK_W-1:0] req_nblk1,
    output logic [1:0]       grant,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4:0]       lane_idx,
    output logic             state_clr,
    output logic             absorb_en,
    output logic             round_en,
    output logic [4:0]       round_idx,
    output logic [1:0]       done
);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_ABSORB, S_PERMUTE, S_SQUEEZE, S_DONE
    } state_t;

    state_t           state, state_nx;
    logic [4:0]       lane_cnt, lane_nx;
    logic [4:0]       round_cnt, round_nx;
    logic [BLK_W-1:0] blk_cnt, blk_nx;
    logic [BLK_W-1:0] nblk, nblk_nx;
    logic [1:0]       grant_q, grant_nx;
    // rr_ptr holds the last owner; rr_vld stays low until a job completes so
    // requester 0 wins the first tie after reset.
    logic             rr_ptr, rr_ptr_nx;
    logic             rr_vld, rr_vld_nx;
    logic             win;
    logic [BLK_W-1:0] nblk_sel;

    assign win      = req[1] & (~req[0] | (rr_vld & ~rr_ptr));
    assign nblk_sel = win ? req_nblk1 : req_nblk0;

    always_ff @(posedge ex_clk or negedge ovr_rst_n) begin
        if (!ovr_rst_n) begin
            state     <= S_IDLE;
            lane_cnt  <= '0;
            round_cnt <= '0;
            blk_cnt   <= '0;
            nblk      <= '0;
            grant_q   <= '0;
            rr_ptr    <= 1'b0;
            rr_vld    <= 1'b0;
        end else begin
            state     <= state_nx;
            lane_cnt  <= lane_nx;
            round_cnt <= round_nx;
            blk_cnt   <= blk_nx;
            nblk      <= nblk_nx;
            grant_q   <= grant_nx;
            rr_ptr    <= rr_ptr_nx;
            rr_vld    <= rr_vld_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        lane_nx   = lane_cnt;
        round_nx  = round_cnt;
        blk_nx    = blk_cnt;
        nblk_nx   = nblk;
        grant_nx  = grant_q;
        rr_ptr_nx = rr_ptr;
        rr_vld_nx = rr_vld;
        case (state)
            S_IDLE: begin
                if (|req) begin
                    grant_nx = win ? 2'b10 : 2'b01;
                    // A zero block count still absorbs one (padding-only) block.
                    nblk_nx  = (nblk_sel == '0) ? BLK_W'(1) : nblk_sel;
                    state_nx = S_CLEAR;
                end
            end
            S_CLEAR: begin
                blk_nx   = '0;
                lane_nx  = '0;
                round_nx = '0;
                state_nx = S_ABSORB;
            end
            S_ABSORB: begin
                if (in_valid) begin
                    if (lane_cnt == 5'(RATE_LANES - 1)) begin
                        lane_nx  = '0;
                        blk_nx   = blk_cnt + BLK_W'(1);
                        state_nx = S_PERMUTE;
                    end else begin
                        lane_nx = lane_cnt + 5'd1;
                    end
                end
            end
            S_PERMUTE: begin
                if (round_cnt == 5'(NUM_ROUNDS - 1)) begin
                    round_nx = '0;
                    state_nx = (blk_cnt < nblk) ? S_ABSORB : S_SQUEEZE;
                end else begin
                    round_nx = round_cnt + 5'd1;
                end
            end
            S_SQUEEZE: begin
                if (out_ready) begin
                    if (lane_cnt == 5'(OUT_LANES - 1)) begin
                        lane_nx  = '0;
                        state_nx = S_DONE;
                    end else begin
                        lane_nx = lane_cnt + 5'd1;
                    end
                end
            end
            S_DONE: begin
                rr_ptr_nx = grant_q[1];
                rr_vld_nx = 1'b1;
                grant_nx  = '0;
                state_nx  = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign grant     = grant_q;
    assign busy      = (state != S_IDLE);
    assign in_ready  = (state == S_ABSORB);
    assign out_valid = (state == S_SQUEEZE);
    assign state_clr = (state == S_CLEAR);
    assign round_en  = (state == S_PERMUTE);
    assign absorb_en = in_valid & in_ready;
    assign lane_idx  = lane_cnt;
    assign round_idx = round_cnt;
    assign done      = (state == S_DONE) ? grant_q : 2'b00;

endmodule

// File: tb/tb_keccak_hash_scheduler.sv
// Directed + randomized bench: a job-level model (arbitration memory, block/lane/round
// loops) predicts every cycle of each job and the grant-held length.
module tb_keccak_hash_scheduler;

    logic       ex_clk = 1'b0;
    logic       ovr_rst_n;
    logic [1:0] req;
    logic [7:0] req_nblk0, req_nblk1;
    logic [1:0] grant, done;
    logic       busy, in_valid, in_ready, out_valid, out_ready;
    logic       state_clr, absorb_en, round_en;
    logic [4:0] lane_idx, round_idx;

    int nvec = 0;
    int nerr = 0;
    // Arbitration memory of the reference model.
    bit have_last = 0;
    int last_owner = 0;

    always #5 ex_clk = ~ex_clk;

    keccak_hash_scheduler dut (
        .ex_clk(ex_clk), .ovr_rst_n(ovr_rst_n), .req(req),
        .req_nblk0(req_nblk0), .req_nblk1(req_nblk1), .grant(grant), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .out_valid(out_valid),
        .out_ready(out_ready), .lane_idx(lane_idx), .state_clr(state_clr),
        .absorb_en(absorb_en), .round_en(round_en), .round_idx(round_idx), .done(done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge ex_clk);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_grant"}, grant, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_clr"}, state_clr, 0);
        chk({tag, "_absorb"}, absorb_en, 0);
        chk({tag, "_round_en"}, round_en, 0);
        chk({tag, "_lane"}, lane_idx, 0);
        chk({tag, "_round_idx"}, round_idx, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    // Runs one full job starting from an IDLE cycle with req already driven.
    // pv/po: percent chance in_valid/out_ready is high in a given cycle.
    task automatic run_job(input int pv, input int po, input bit drop_req);
        int owner, nb, lane, stalls, gcnt, nabs;
        logic [1:0] exp_g;
        logic iv, orr;
        if (req == 2'b01) owner = 0;
        else if (req == 2'b10) owner = 1;
        else owner = have_last ? 1 - last_owner : 0;
        nb = (owner == 0) ? int'(req_nblk0) : int'(req_nblk1);
        if (nb == 0) nb = 1;
        exp_g = (owner == 0) ? 2'b01 : 2'b10;
        stalls = 0; gcnt = 0; nabs = 0;

        #1 chk("idle_grant", grant, 0);
        chk("idle_busy", busy, 0);
        step();
        #1 chk("clr_pulse", state_clr, 1);
        chk("clr_grant", grant, exp_g);
        chk("clr_busy", busy, 1);
        gcnt += (grant != 0);
        step();
        for (int b = 0; b < nb; b++) begin
            lane = 0;
            while (lane < 17) begin
                iv = ($urandom_range(99) < pv);
                in_valid = iv;
                out_ready = $urandom_range(1);
                #1 chk("abs_ready", in_ready, 1);
                chk("abs_lane", lane_idx, lane);
                chk("abs_en", absorb_en, iv);
                chk("abs_round_en", round_en, 0);
                chk("abs_clr", state_clr, 0);
                gcnt += (grant != 0);
                nabs += absorb_en;
                if (iv) lane++; else stalls++;
                step();
            end
            for (int r = 0; r < 24; r++) begin
                in_valid = $urandom_range(1);
                out_ready = $urandom_range(1);
                if (drop_req && b == 0 && r == 5) req = 2'b00;
                #1 chk("perm_round_en", round_en, 1);
                chk("perm_round_idx", round_idx, r);
                chk("perm_in_ready", in_ready, 0);
                chk("perm_absorb", absorb_en, 0);
                gcnt += (grant != 0);
                step();
            end
        end
        chk("absorb_count", nabs, 17 * nb);
        lane = 0;
        while (lane < 4) begin
            orr = ($urandom_range(99) < po);
            out_ready = orr;
            in_valid = $urandom_range(1);
            #1 chk("sq_valid", out_valid, 1);
            chk("sq_lane", lane_idx, lane);
            chk("sq_in_ready", in_ready, 0);
            chk("sq_done", done, 0);
            gcnt += (grant != 0);
            if (orr) lane++; else stalls++;
            step();
        end
        in_valid = 0; out_ready = 0;
        #1 chk("done_pulse", done, exp_g);
        chk("done_out_valid", out_valid, 0);
        gcnt += (grant != 0);
        chk("job_cycles", gcnt, 47 + 41 * (nb - 1) + stalls);
        have_last = 1;
        last_owner = owner;
        step();
    endtask

    initial begin
        ovr_rst_n = 0; req = 0; req_nblk0 = 0; req_nblk1 = 0;
        in_valid = 0; out_ready = 0;
        step(); step();
        #1 chk_quiet("reset");
        step();
        ovr_rst_n = 1;

        // Single block, no stalls, requester 0.
        req = 2'b01; req_nblk0 = 8'd1;
        run_job(100, 100, 0);
        req = 2'b00;

        // Three blocks, no stalls, requester 1.
        req = 2'b10; req_nblk1 = 8'd3;
        run_job(100, 100, 0);
        req = 2'b00;

        // Both requesting continuously: grants alternate.
        req = 2'b11;
        for (int j = 0; j < 4; j++) begin
            req_nblk0 = 8'($urandom_range(1, 2));
            req_nblk1 = 8'($urandom_range(1, 2));
            run_job(100, 100, 0);
        end
        req = 2'b00;

        // Random stalls on a two-block job.
        req = 2'b01; req_nblk0 = 8'd2;
        run_job(50, 50, 0);
        req = 2'b10; req_nblk1 = 8'd2;
        run_job(60, 40, 0);

        // Request dropped during permutation: job still completes.
        req = 2'b10; req_nblk1 = 8'd1;
        run_job(100, 100, 1);
        for (int k = 0; k < 3; k++) begin
            #1 chk("after_drop_grant", grant, 0);
            chk("after_drop_done", done, 0);
            step();
        end

        // Reset mid-absorb: immediate quiet outputs, no done, no spontaneous grant.
        req = 2'b01; req_nblk0 = 8'd1;
        step(); step();
        in_valid = 1;
        for (int k = 0; k < 3; k++) step();
        #1 ovr_rst_n = 0;
        #1 chk_quiet("mid_reset");
        req = 2'b00;
        have_last = 0;
        step();
        ovr_rst_n = 1; in_valid = 0;
        for (int k = 0; k < 5; k++) begin
            #1 chk("post_reset_grant", grant, 0);
            chk("post_reset_done", done, 0);
            step();
        end

        // First tie after reset again goes to requester 0.
        req = 2'b11; req_nblk0 = 8'd1; req_nblk1 = 8'd1;
        run_job(100, 100, 0);
        req = 2'b00;

        // Zero block count behaves as one block.
        req = 2'b01; req_nblk0 = 8'd0;
        run_job(100, 100, 0);
        req = 2'b00;

        // Maximum block count completes without counter wrap.
        req = 2'b10; req_nblk1 = 8'd255;
        run_job(100, 100, 0);
        req = 2'b00;

        #1 chk("final_idle", busy, 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
